// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 (g0=7, g1=5) code: defaults,
// state/metric types and the branch-output function used by encoder and decoder.
package viterbi_pkg;
  localparam int TB_DEPTH_DEF = 16;
  localparam int METRIC_W_DEF = 6;
  localparam int METRIC_INIT  = 16;

  typedef logic [1:0]              state_t;
  typedef logic [METRIC_W_DEF-1:0] metric_t;

  // Expected {c1,c0} when input bit b leaves state s={u[n-1],u[n-2]}.
  function automatic logic [1:0] branch_out(input state_t s, input logic b);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state: picks the cheaper of two predecessors
// (predecessor 0 wins ties) and shifts the new decision bit into its survivor.
module viterbi_acs #(
  parameter int METRIC_W = 6,
  parameter int TB_DEPTH = 16
) (
  input  logic [METRIC_W-1:0] metric0_i,
  input  logic [METRIC_W-1:0] metric1_i,
  input  logic [1:0]          bm0_i,
  input  logic [1:0]          bm1_i,
  input  logic [TB_DEPTH-1:0] surv0_i,
  input  logic [TB_DEPTH-1:0] surv1_i,
  input  logic                dec_bit_i,
  output logic [METRIC_W-1:0] metric_o,
  output logic [TB_DEPTH-1:0] surv_o
);
  localparam int SW = METRIC_W + 1;

  logic [SW-1:0]       sum0;
  logic [SW-1:0]       sum1;
  logic [SW-1:0]       sum_sel;
  logic [TB_DEPTH-1:0] surv_sel;
  logic                take1;

  // One guard bit keeps the compare exact; the saturate never fires while
  // normalization keeps the metric spread small.
  assign sum0     = {1'b0, metric0_i} + SW'(bm0_i);
  assign sum1     = {1'b0, metric1_i} + SW'(bm1_i);
  assign take1    = sum1 < sum0;
  assign sum_sel  = take1 ? sum1 : sum0;
  assign metric_o = sum_sel[SW-1] ? '1 : sum_sel[METRIC_W-1:0];
  assign surv_sel = take1 ? surv1_i : surv0_i;
  assign surv_o   = (surv_sel << 1) | TB_DEPTH'(dec_bit_i);
endmodule

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision register-exchange Viterbi decoder for the K=3 (7,5) code.
// One symbol per enabled cycle; decoded bit emerges TB_DEPTH-1 symbols later.
module viterbi_decoder_k3
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int METRIC_W = METRIC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out,
  output logic       valid_o
);
  localparam int CNT_W = $clog2(TB_DEPTH + 1);

  logic [METRIC_W-1:0] metric_q   [4];
  logic [METRIC_W-1:0] acs_metric [4];
  logic [METRIC_W-1:0] metric_d   [4];
  logic [TB_DEPTH-1:0] surv_q     [4];
  logic [TB_DEPTH-1:0] surv_d     [4];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                d_out_q;
  logic                d_out_d;
  logic                valid_q;
  logic                valid_d;
  logic                norm;
  state_t              best;

  // Next state ns is reached from {ns[0],0} and {ns[0],1} with input bit ns[1].
  for (genvar gi = 0; gi < 4; gi++) begin : g_acs
    localparam logic [1:0] NS = 2'(gi);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};

    logic [1:0] diff0;
    logic [1:0] diff1;
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign diff0 = d_in ^ branch_out(P0, NS[1]);
    assign diff1 = d_in ^ branch_out(P1, NS[1]);
    assign bm0   = 2'(diff0[1]) + 2'(diff0[0]);
    assign bm1   = 2'(diff1[1]) + 2'(diff1[0]);

    viterbi_acs #(
      .METRIC_W (METRIC_W),
      .TB_DEPTH (TB_DEPTH)
    ) u_acs (
      .metric0_i (metric_q[P0]),
      .metric1_i (metric_q[P1]),
      .bm0_i     (bm0),
      .bm1_i     (bm1),
      .surv0_i   (surv_q[P0]),
      .surv1_i   (surv_q[P1]),
      .dec_bit_i (NS[1]),
      .metric_o  (acs_metric[gi]),
      .surv_o    (surv_d[gi])
    );
  end

  // Dropping a shared MSB subtracts the same amount from every metric.
  always_comb begin
    norm = acs_metric[0][METRIC_W-1] & acs_metric[1][METRIC_W-1] &
           acs_metric[2][METRIC_W-1] & acs_metric[3][METRIC_W-1];
    for (int i = 0; i < 4; i++) begin
      metric_d[i] = acs_metric[i];
      if (norm) metric_d[i][METRIC_W-1] = 1'b0;
    end
  end

  always_comb begin
    best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (metric_d[i] < metric_d[best]) best = state_t'(i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_W'(TB_DEPTH)) cnt_d = cnt_q + 1'b1;
    valid_d = enable && (cnt_q >= CNT_W'(TB_DEPTH - 1));
    d_out_d = enable ? surv_d[best][TB_DEPTH-1] : d_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        metric_q[i] <= (i == 0) ? '0 : METRIC_W'(METRIC_INIT);
        surv_q[i]   <= '0;
      end
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      d_out_q <= d_out_d;
      if (enable) begin
        for (int i = 0; i < 4; i++) begin
          metric_q[i] <= metric_d[i];
          surv_q[i]   <= surv_d[i];
        end
        cnt_q <= cnt_d;
      end
    end
  end

  assign d_out   = d_out_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Directed bench for viterbi_decoder_k3: table of channel scenarios plus
// hand-written reset and tie-break sequences, checked against a behavioural model.
module tb_viterbi_decoder_k3;
  localparam int TBD = 16;
  localparam int MW  = 6;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;
  logic       valid_o;

  viterbi_decoder_k3 #(.TB_DEPTH(TBD), .METRIC_W(MW)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .d_in    (d_in),
    .d_out   (d_out),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;
    int         nbits;
    int         err_sym;
    logic [1:0] err_mask;
    int         err_per;
    bit         stall;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [4];

  int       checks;
  int       errors;
  int       pulses;
  int       bit_errs;
  int       out_idx;
  bit       check_truth;
  logic     truth [1024];

  // Behavioural reference decoder (integer metrics, wrap flagged explicitly)
  int          mm [4];
  logic [15:0] ms [4];
  int          mcnt;
  logic        m_dout;
  bit          m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ham(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return int'(x[1]) + int'(x[0]);
  endfunction

  function automatic logic [1:0] enc_out(input logic [1:0] s, input logic b);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  task automatic model_reset();
    mm[0] = 0; mm[1] = 16; mm[2] = 16; mm[3] = 16;
    for (int i = 0; i < 4; i++) ms[i] = '0;
    mcnt   = 0;
    m_dout = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] sym, output bit v);
    int          nm [4];
    logic [15:0] nsv [4];
    logic [1:0]  p0, p1;
    logic        b;
    int          c0, c1, bst;
    bit          all_hi;
    for (int ns = 0; ns < 4; ns++) begin
      b  = (ns >= 2);
      p0 = (ns % 2 == 1) ? 2'd2 : 2'd0;
      p1 = p0 + 2'd1;
      c0 = mm[p0] + ham(sym, enc_out(p0, b));
      c1 = mm[p1] + ham(sym, enc_out(p1, b));
      if (c0 <= c1) begin
        nm[ns] = c0; nsv[ns] = {ms[p0][14:0], b};
      end else begin
        nm[ns] = c1; nsv[ns] = {ms[p1][14:0], b};
      end
    end
    all_hi = 1;
    for (int i = 0; i < 4; i++) begin
      if (nm[i] >= 64) m_wrap = 1;
      if (nm[i] < 32) all_hi = 0;
    end
    bst = 0;
    for (int i = 0; i < 4; i++) begin
      if (all_hi) nm[i] = nm[i] - 32;
      mm[i] = nm[i];
      ms[i] = nsv[i];
    end
    for (int i = 1; i < 4; i++) if (mm[i] < mm[bst]) bst = i;
    if (mcnt < TBD) mcnt++;
    m_dout = ms[bst][15];
    v      = (mcnt >= TBD);
  endtask

  // One clock: drive inputs, step model if enabled, compare everything #1 after the edge.
  task automatic cycle(input bit en, input logic [1:0] sym);
    bit ev;
    ev     = 0;
    enable = en;
    d_in   = sym;
    if (en) model_step(sym, ev);
    @(posedge clk);
    #1;
    chk("valid", {31'd0, valid_o}, {31'd0, ev});
    chk("dout", {31'd0, d_out}, {31'd0, m_dout});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("metric%0d", i), 32'(dut.metric_q[i]), 32'(mm[i]));
      chk($sformatf("surv%0d", i), 32'(dut.surv_q[i]), 32'(ms[i]));
    end
    if (valid_o) begin
      pulses++;
      if (check_truth) begin
        if (d_out !== truth[out_idx]) bit_errs++;
        chk($sformatf("bit%0d", out_idx), {31'd0, d_out}, {31'd0, truth[out_idx]});
      end
      out_idx++;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    pulses   = 0;
    bit_errs = 0;
    out_idx  = 0;
  endtask

  task automatic fill_truth(input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) truth[i] = pat[i % 8];
  endtask

  // Encode truth[0..n-1] from state 0 and push through the decoder.
  task automatic run_stream(input vec_t v, input int n);
    logic [1:0] es;
    logic [1:0] sym;
    logic       b;
    es = 2'd0;
    for (int i = 0; i < n; i++) begin
      b   = truth[i];
      sym = enc_out(es, b);
      es  = {b, es[1]};
      if (i == v.err_sym) sym = sym ^ v.err_mask;
      if (v.err_per > 0 && (i % v.err_per) == v.err_per - 1) sym = sym ^ v.err_mask;
      cycle(1'b1, sym);
      if (v.stall) begin
        cycle(1'b0, 2'($urandom_range(3, 0)));
        cycle(1'b0, 2'($urandom_range(3, 0)));
      end
    end
  endtask

  initial begin
    int   first_valid;
    vec_t plain;
    clk = 0; rst = 0; enable = 0; d_in = 2'b00;
    checks = 0; errors = 0; pulses = 0; bit_errs = 0; out_idx = 0; m_wrap = 0;
    check_truth = 1;

    vecs[0] = '{pat: 8'hB5, nbits: 64,   err_sym: -1, err_mask: 2'b00, err_per: 0, stall: 0, exp_pulses: 49};
    vecs[1] = '{pat: 8'hB5, nbits: 64,   err_sym: 10, err_mask: 2'b10, err_per: 0, stall: 0, exp_pulses: 49};
    vecs[2] = '{pat: 8'hB5, nbits: 64,   err_sym: -1, err_mask: 2'b00, err_per: 0, stall: 1, exp_pulses: 49};
    vecs[3] = '{pat: 8'h00, nbits: 1000, err_sym: -1, err_mask: 2'b11, err_per: 7, stall: 0, exp_pulses: 985};
    plain   = '{pat: 8'hB5, nbits: 0,    err_sym: -1, err_mask: 2'b00, err_per: 0, stall: 0, exp_pulses: 0};

    // Reset state while rst is still low
    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_dout", {31'd0, d_out}, 32'd0);
    chk("rst_metric0", 32'(dut.metric_q[0]), 32'd0);
    chk("rst_metric3", 32'(dut.metric_q[3]), 32'd16);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      m_wrap = 0;
      fill_truth(vecs[v].pat, vecs[v].nbits);
      run_stream(vecs[v], vecs[v].nbits);
      chk($sformatf("pulses_v%0d", v), 32'(pulses), 32'(vecs[v].exp_pulses));
      chk($sformatf("biterrs_v%0d", v), 32'(bit_errs), 32'd0);
      chk($sformatf("nowrap_v%0d", v), {31'd0, m_wrap}, 32'd0);
      $display("scenario %0d: symbols=%0d pulses=%0d bit_errors=%0d", v, vecs[v].nbits, pulses, bit_errs);
    end

    // Tie-break: first symbol 01 after reset
    do_reset();
    check_truth = 0;
    cycle(1'b1, 2'b01);
    chk("tie_m0", 32'(dut.metric_q[0]), 32'd1);
    chk("tie_m1", 32'(dut.metric_q[1]), 32'd16);
    chk("tie_m2", 32'(dut.metric_q[2]), 32'd1);
    chk("tie_m3", 32'(dut.metric_q[3]), 32'd16);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_lsb%0d", i), {31'd0, dut.surv_q[i][0]}, (i >= 2) ? 32'd1 : 32'd0);
    cycle(1'b0, 2'b11);
    $display("tie-break: metrics=%0d,%0d,%0d,%0d", mm[0], mm[1], mm[2], mm[3]);

    // Reset mid-stream after 30 symbols, then restart
    check_truth = 1;
    do_reset();
    fill_truth(8'hB5, 64);
    run_stream(plain, 30);
    chk("pre_rst_pulses", 32'(pulses), 32'd15);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_dout", {31'd0, d_out}, 32'd0);
    chk("mid_rst_metric1", 32'(dut.metric_q[1]), 32'd16);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    pulses = 0; bit_errs = 0; out_idx = 0;
    first_valid = -1;
    begin
      logic [1:0] es;
      logic       b;
      es = 2'd0;
      for (int k = 0; k < 20; k++) begin
        b = truth[k];
        cycle(1'b1, enc_out(es, b));
        es = {b, es[1]};
        if (valid_o && first_valid < 0) first_valid = k;
      end
    end
    chk("restart_first_valid", 32'(first_valid), 32'd15);
    chk("restart_pulses", 32'(pulses), 32'd5);
    $display("mid-stream reset: first_valid_symbol=%0d pulses=%0d bit_errors=%0d", first_valid, pulses, bit_errs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
